instr_memory: RTL
=================

// Module: instr_memory
// PURPOSE
//  Instruction-memory responder for the fetch port of mips_cpu_harvard: answers instr_address with instr_readdata
//  in the same cycle, word array mapped at the reset vector. Program is written beforehand through a streaming
//  valid/ready load port with an auto-incrementing pointer, so benches and loaders no longer hand-decode addresses.
//  Sits beside data_memory; the CPU connects only to the fetch side.
// PARAMETERS
//  AW         10             log2 of depth in 32-bit words (DEPTH = 2**AW)
//  BASE_ADDR  32'hBFC00000   byte address of word 0 (reset vector)
//  NOP_WORD   32'h00000000   value returned for any non-served fetch
// PORTS
//  clk            in   1     single clock, all state on posedge
//  reset          in   1     synchronous, active-high
//  clk_enable     in   1     0 = freeze FSM, pointer and array writes (fetch read stays combinational)
//  load_start     in   1     pulse: begin (or restart) a program load
//  load_valid     in   1     load_data holds a word
//  load_data      in   32    instruction word to store
//  load_last      in   1     qualifies final word of program (with load_valid)
//  load_ready     out  1     word accepted this cycle when load_valid & load_ready
//  load_done      out  1     program complete, fetches served
//  load_error     out  1     sticky: more than DEPTH words offered in current load
//  word_count     out  AW+1  number of words stored by current/last load
//  instr_address  in   32    CPU fetch byte address
//  instr_readdata out  32    fetched word, combinational from instr_address
//  fetch_fault    out  1     RUN-state fetch outside loaded image (address 0 exempt)
// BEHAVIOUR
//  Reset: state IDLE, ptr=0, word_count=0, load_done=0, load_error=0; array contents NOT cleared.
//  FSM IDLE -> LOAD on load_start; LOAD -> RUN on accepted word with load_last; RUN -> LOAD on load_start;
//   load_start in LOAD restarts it. Every LOAD entry: ptr=0, word_count=0, load_error=0, load_done=0.
//  load_ready = (state==LOAD) & !load_start & clk_enable; restart wins over a same-cycle word (not written).
//  Accept (valid&ready): if ptr<DEPTH write mem[ptr]<=load_data, ptr++, word_count++;
//   else drop word, load_error<=1. load_last still ends load, even when dropped/overflowed.
//  load_done = (state==RUN), registered; word_count holds its value in RUN.
//  Fetch: off = instr_address - BASE_ADDR (32-bit wrap); hit = RUN & off[1:0]==0 & (off>>2) < word_count.
//   hit -> mem[off>>2]; otherwise NOP_WORD. Zero-cycle latency (CPU samples same cycle).
//  fetch_fault = RUN & !hit & instr_address!=0 (jump to 0 is the halt convention, not a fault).
//  IDLE/LOAD: instr_readdata=NOP_WORD, fetch_fault=0. Addresses below BASE_ADDR wrap to huge off -> miss.
//  clk_enable=0: no state, pointer, counter or array change; load_ready=0.
//  Reset mid-load: IDLE, counters cleared, partial image never served until a complete reload.
// STRUCTURE
//  Package mips_mem_pkg: RESET_VECTOR=32'hBFC00000, NOP_WORD, typedef enum {IMEM_IDLE, IMEM_LOAD, IMEM_RUN}.
//  Sub-module instr_ram: DEPTH x 32, one sync write port, one async read port; FSM/pointer/fetch
//  decode stay in instr_memory.
// TESTING
//  1 Load 3C010001,3C030004,00231021,00000008,24000000 (last on 5th) -> load_done=1, word_count=5;
//    fetch BFC00008 -> 00231021; BFC00010 -> 24000000.
//  2 After 1: fetch BFC00014 -> 00000000, fetch_fault=1; BFC00006 (misaligned) -> 0, fault=1; 0 -> 0, fault=0.
//  3 AW=2: offer 6 words, last on 6th -> word_count=4, load_error=1, RUN; fetch BFC0000C -> word 4.
//  4 Reset after 2 of 5 words -> IDLE, word_count=0, load_done=0; fetch BFC00000 -> 0, fault=0.
//  5 load_start in RUN, reload 1 word 11111111 -> word_count=1; BFC00004 -> 0 and fault=1 (stale word hidden).
//  6 clk_enable=0 with load_valid held 3 cycles -> load_ready=0, word_count unchanged; resume -> one write.
//  Same-cycle load_start+load_valid in LOAD -> ptr=0, word not stored, load_ready=0 that cycle.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS instruction/data memory responders.
//   RESET_VECTOR : byte address where the CPU starts fetching
//   NOP_WORD     : word returned for any fetch that is not served from the image
//   imem_state_t : instruction-memory loader/run state
package mips_mem_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP_WORD     = 32'h00000000;

    typedef enum logic [1:0] {
        IMEM_IDLE,
        IMEM_LOAD,
        IMEM_RUN
    } imem_state_t;

endpackage

// File: rtl/instr_ram.sv
// Word array for instr_memory: DEPTH = 2**AW words of 32 bits.
//   clk         : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous (combinational) read port
// Contents are not reset; a program image is always written before it is served.
module instr_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_memory.sv
// Instruction-memory responder for the fetch port of mips_cpu_harvard.
// A program is streamed in through a valid/ready load port with an
// auto-incrementing pointer; once the final word is accepted the image is
// served combinationally at BASE_ADDR.
//   clk, reset          : clock, synchronous active-high reset
//   clk_enable          : 0 freezes FSM, pointer and array writes
//   load_start          : begin/restart a program load
//   load_valid/data/last, load_ready : word stream
//   load_done           : image complete, fetches served
//   load_error          : sticky, more than DEPTH words offered in this load
//   word_count          : words stored by the current/last load
//   instr_address -> instr_readdata, fetch_fault : zero-latency fetch port
module instr_memory #(
    parameter int          AW        = 10,
    parameter logic [31:0] BASE_ADDR = mips_mem_pkg::RESET_VECTOR,
    parameter logic [31:0] NOP_WORD  = mips_mem_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done,
    output logic        load_error,
    output logic [AW:0] word_count,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        fetch_fault
);

    import mips_mem_pkg::*;

    localparam int DEPTH = 2**AW;

    imem_state_t   state, state_next;
    // Write pointer doubles as the stored-word count: every stored word
    // advances both, and both clear together on LOAD entry.
    logic [AW:0]   ptr, ptr_next;
    logic          err_next;
    logic          accept;
    logic          we;
    logic [31:0]   off;
    logic [31:0]   rdata;
    logic          hit;

    // Restart takes priority over a word offered in the same cycle.
    assign load_ready = (state == IMEM_LOAD) && !load_start && clk_enable;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        err_next   = load_error;
        we         = 1'b0;
        if (load_start) begin
            state_next = IMEM_LOAD;
            ptr_next   = '0;
            err_next   = 1'b0;
        end else if (accept) begin
            if (ptr < (AW+1)'(DEPTH)) begin
                we       = 1'b1;
                ptr_next = ptr + 1'b1;
            end else begin
                err_next = 1'b1;
            end
            // An overflowing last word still terminates the load.
            if (load_last) state_next = IMEM_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IMEM_IDLE;
            ptr        <= '0;
            load_error <= 1'b0;
            load_done  <= 1'b0;
        end else if (clk_enable) begin
            state      <= state_next;
            ptr        <= ptr_next;
            load_error <= err_next;
            load_done  <= (state_next == IMEM_RUN);
        end
    end

    assign word_count = ptr;

    instr_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr[AW-1:0]),
        .wdata (load_data),
        .raddr (off[AW+1:2]),
        .rdata (rdata)
    );

    // Addresses below BASE_ADDR wrap to a huge offset and miss the count test.
    assign off = instr_address - BASE_ADDR;
    assign hit = (state == IMEM_RUN) && (off[1:0] == 2'b00) &&
                 (off[31:2] < 30'(ptr));

    assign instr_readdata = hit ? rdata : NOP_WORD;
    // Jumping to address 0 is the halt convention, never a fault.
    assign fetch_fault    = (state == IMEM_RUN) && !hit && (instr_address != 32'h0);

endmodule
